// File: rtl/rr_tree_arb_pkg.sv
// ============================================================================
//  Module : rr_tree_arb_pkg
//  Brief  : Shared state encoding and pointer-width helpers for rr_tree_arb.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_tree_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        REL   = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    // Search pointer width: clog2(N), but never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_tree_arb_pick.sv
// ============================================================================
//  Module : rr_pick
//  Brief  : Combinational round-robin picker: rotate, priority-encode, rotate back.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] idx
);

    localparam logic [PTR_W:0] NN = (PTR_W+1)'(N);

    logic [N-1:0]     w_rot;
    logic [PTR_W-1:0] w_off;
    logic [PTR_W:0]   w_sum;

    // Bit 0 of the rotated vector corresponds to requester ptr.
    assign w_rot = N'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = PTR_W'(i);
        end
    end

    assign w_sum  = {1'b0, w_off} + {1'b0, ptr};
    assign idx    = PTR_W'((w_sum >= NN) ? (w_sum - NN) : w_sum);
    assign onehot = (|req) ? (N'(1) << idx) : '0;

endmodule

`default_nettype wire

// File: rtl/rr_tree_arb.sv
// ============================================================================
//  Module : rr_tree_arb
//  Brief  : Clocked N-way round-robin arbiter node for arbitration trees.
//           Optional high-priority mask port enabled by RR_TREE_ARB_PRIO_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_tree_arb
    import rr_tree_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ROOT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         treq,
    input  logic         tgnt
`ifdef RR_TREE_ARB_PRIO_EN
    ,
    input  logic [N-1:0] prio
`endif
);

    localparam int               PTR_W = ptr_width(N);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N - 1);

    state_t           r_state, w_state_nxt;
    logic [N-1:0]     r_gnt, w_gnt_nxt;
    logic             r_treq, w_treq_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0] r_widx, w_widx_nxt;

    logic [N-1:0]     w_cand;
    logic [N-1:0]     w_pick_oh;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_go;

`ifdef RR_TREE_ARB_PRIO_EN
    logic [N-1:0] w_hp;
    assign w_hp   = req & prio;
    assign w_cand = (|w_hp) ? w_hp : req;
`else
    assign w_cand = req;
`endif

    // A root has no parent, so its grant is implicitly immediate.
    assign w_go = (ROOT != 0) ? 1'b1 : tgnt;

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (w_cand),
        .ptr    (r_ptr),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_treq  <= 1'b0;
            r_ptr   <= '0;
            r_widx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_treq  <= w_treq_nxt;
            r_ptr   <= w_ptr_nxt;
            r_widx  <= w_widx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_treq_nxt  = r_treq;
        w_ptr_nxt   = r_ptr;
        w_widx_nxt  = r_widx;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_treq_nxt  = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_go) begin
                    if (|w_cand) begin
                        w_gnt_nxt   = w_pick_oh;
                        w_widx_nxt  = w_pick_idx;
                        w_state_nxt = GRANT;
                    end else begin
                        w_treq_nxt  = 1'b0;
                        w_state_nxt = (ROOT != 0) ? IDLE : REL;
                    end
                end
            end
            GRANT: begin
                if (!req[r_widx]) begin
                    w_gnt_nxt   = '0;
                    w_treq_nxt  = 1'b0;
                    w_ptr_nxt   = (r_widx == LAST) ? '0 : r_widx + 1'b1;
                    w_state_nxt = (ROOT != 0) ? IDLE : REL;
                end
            end
            REL: begin
                // Parent must withdraw its grant before a new request is raised.
                if (!tgnt) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign gnt  = r_gnt;
    assign treq = r_treq;

endmodule

`default_nettype wire

// File: tb/tb_rr_tree_arb.sv
// ============================================================================
//  Module : tb_rr_tree_arb
//  Brief  : Scoreboard bench for a root and a non-root rr_tree_arb, N=4.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_tree_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_r = '0, req_n = '0;
    logic [3:0] gnt_r, gnt_n;
    logic       treq_r, treq_n;
    logic       tgnt = 1'b0;
    logic       tgnt_unused = 1'b0;
`ifdef RR_TREE_ARB_PRIO_EN
    logic [3:0] prio_r = '0, prio_n = '0;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    logic [3:0] q_root[$];
    logic [3:0] q_node[$];
    logic [3:0] prev_r = '0, prev_n = '0;

    always #5 clk = ~clk;

    rr_tree_arb #(.N(4), .ROOT(1)) u_root (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_r),
        .gnt   (gnt_r),
        .treq  (treq_r),
        .tgnt  (tgnt_unused)
`ifdef RR_TREE_ARB_PRIO_EN
        ,
        .prio  (prio_r)
`endif
    );

    rr_tree_arb #(.N(4), .ROOT(0)) u_node (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_n),
        .gnt   (gnt_n),
        .treq  (treq_n),
        .tgnt  (tgnt)
`ifdef RR_TREE_ARB_PRIO_EN
        ,
        .prio  (prio_n)
`endif
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitors: every new non-zero grant pops one expected value.
    always @(negedge clk) begin
        if (rst_n && gnt_r !== prev_r && gnt_r != 4'b0) begin
            if (q_root.size() == 0) chk("root unexpected grant", gnt_r, 4'b0000);
            else                    chk("root grant", gnt_r, q_root.pop_front());
            chk("root treq during grant", {3'b0, treq_r}, 4'b0001);
        end
        prev_r <= gnt_r;
    end

    always @(negedge clk) begin
        if (rst_n && gnt_n !== prev_n && gnt_n != 4'b0) begin
            if (q_node.size() == 0) chk("node unexpected grant", gnt_n, 4'b0000);
            else                    chk("node grant", gnt_n, q_node.pop_front());
            chk("node treq during grant", {3'b0, treq_n}, 4'b0001);
        end
        prev_n <= gnt_n;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_r = '0;
        req_n = '0;
        tgnt  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt_r(output logic [3:0] g);
        g = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt_r != 4'b0) break;
        end
        g = gnt_r;
        if (g == 4'b0) begin
            n_vec++;
            n_miss++;
            $display("FAIL root grant timeout: got %b, expected a grant", g);
        end
    endtask

    // Requester withdraws the granted bit; the grant must clear one edge later.
    task automatic serve_r();
        logic [3:0] g;
        wait_gnt_r(g);
        req_r = req_r & ~g;
        @(negedge clk);
        chk("root gnt gap", gnt_r, 4'b0000);
        chk("root treq gap", {3'b0, treq_r}, 4'b0000);
    endtask

    initial begin
        logic [3:0] g;
        bit         seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset gnt root", gnt_r, 4'b0000);
        chk("reset treq root", {3'b0, treq_r}, 4'b0000);
        chk("reset gnt node", gnt_n, 4'b0000);
        chk("reset treq node", {3'b0, treq_n}, 4'b0000);
        rst_n = 1'b1;

        // 1: root latency, req=0010
        @(negedge clk);
        q_root.push_back(4'b0010);
        req_r = 4'b0010;
        @(negedge clk);
        chk("t1 treq after edge0", {3'b0, treq_r}, 4'b0001);
        chk("t1 gnt after edge0", gnt_r, 4'b0000);
        @(negedge clk);
        chk("t1 gnt after edge1", gnt_r, 4'b0010);
        req_r = 4'b0000;
        @(negedge clk);
        chk("t1 gnt released", gnt_r, 4'b0000);

        // 3: grant 2 (ptr->3), then req=0011 wraps to 0, then 1 is served
        q_root.push_back(4'b0100);
        req_r = 4'b0100;
        serve_r();
        q_root.push_back(4'b0001);
        q_root.push_back(4'b0010);
        req_r = 4'b0011;
        serve_r();
        serve_r();

        // 2: all four requesting; requester 0 re-requests after its first grant
        do_reset();
        q_root.push_back(4'b0001);
        q_root.push_back(4'b0010);
        q_root.push_back(4'b0100);
        q_root.push_back(4'b1000);
        q_root.push_back(4'b0001);
        req_r = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve_r();
            if (k == 0) req_r = req_r | 4'b0001;
        end

        // 4: non-root waits for tgnt
        do_reset();
        req_n = 4'b0100;
        seen  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (gnt_n != 4'b0) seen = 1'b1;
        end
        chk("t4 treq while tgnt=0", {3'b0, treq_n}, 4'b0001);
        chk("t4 no gnt while tgnt=0", {3'b0, seen}, 4'b0000);
        q_node.push_back(4'b0100);
        tgnt = 1'b1;
        @(negedge clk);
        chk("t4 gnt after tgnt", gnt_n, 4'b0100);
        req_n = 4'b0000;
        @(negedge clk);
        chk("t4 gnt released", gnt_n, 4'b0000);
        chk("t4 treq released", {3'b0, treq_n}, 4'b0000);
        req_n = 4'b0001;
        seen  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (gnt_n != 4'b0 || treq_n) seen = 1'b1;
        end
        chk("t4 REL holds while tgnt=1", {3'b0, seen}, 4'b0000);
        tgnt = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4 treq re-raised", {3'b0, treq_n}, 4'b0001);
        chk("t4 no gnt before tgnt", gnt_n, 4'b0000);
        q_node.push_back(4'b0001);
        tgnt = 1'b1;
        @(negedge clk);
        chk("t4 second gnt", gnt_n, 4'b0001);
        req_n = 4'b0000;
        @(negedge clk);
        tgnt = 1'b0;

        // 5: asynchronous reset mid-grant
        do_reset();
        q_root.push_back(4'b1000);
        req_r = 4'b1000;
        wait_gnt_r(g);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 async gnt clear", gnt_r, 4'b0000);
        chk("t5 async treq clear", {3'b0, treq_r}, 4'b0000);
        @(negedge clk);
        req_r = 4'b1111;
        q_root.push_back(4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt_r(g);
        req_r = 4'b0000;
        repeat (2) @(negedge clk);

`ifdef RR_TREE_ARB_PRIO_EN
        // 6: priority mask
        do_reset();
        prio_r = 4'b0100;
        q_root.push_back(4'b0100);
        req_r = 4'b1111;
        wait_gnt_r(g);
        req_r = 4'b0000;
        do_reset();
        prio_r = 4'b0000;
        q_root.push_back(4'b0001);
        req_r = 4'b1111;
        wait_gnt_r(g);
        req_r = 4'b0000;
        repeat (2) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("root scoreboard drained", 4'(q_root.size()), 4'd0);
        chk("node scoreboard drained", 4'(q_node.size()), 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
